// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : PC sequencer and instruction register for the 4-bit CPU, with
//            run/stall/branch/halt control from the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RUN,
  input  logic        STALL,
  input  logic        BR_TAKEN,
  input  logic [3:0]  BR_TARGET,
  input  logic        HALT_REQ,
  input  logic [10:0] INS_IN,
  output logic [3:0]  PC,
  output logic [10:0] IR,
  output logic [3:0]  IR_PC,
  output logic        IR_VALID,
  output logic        HALTED,
  output logic        WRAP
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [3:0] c_PC_LAST = 4'hF;

  state_t      r_state, w_next_state;
  logic [3:0]  r_pc, w_pc_next;
  logic [10:0] r_ir, w_ir_next;
  logic [3:0]  r_ir_pc, w_ir_pc_next;
  logic        r_ir_valid, w_ir_valid_next;
  logic        r_halted, w_halted_next;
  logic        r_wrap, w_wrap_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_ir       <= 11'b0;
      r_ir_pc    <= 4'h0;
      r_ir_valid <= 1'b0;
      r_halted   <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_pc       <= w_pc_next;
      r_ir       <= w_ir_next;
      r_ir_pc    <= w_ir_pc_next;
      r_ir_valid <= w_ir_valid_next;
      r_halted   <= w_halted_next;
      r_wrap     <= w_wrap_next;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_pc_next       = r_pc;
    w_ir_next       = r_ir;
    w_ir_pc_next    = r_ir_pc;
    w_ir_valid_next = r_ir_valid;
    w_wrap_next     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ir_valid_next = 1'b0;
        if (RUN) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        if (HALT_REQ) begin
          w_next_state    = S_HALTED;
          w_ir_valid_next = 1'b0;
        end else if (BR_TAKEN) begin
          // Redirect wins over stall; the word fetched this cycle is dropped.
          w_pc_next       = BR_TARGET;
          w_ir_valid_next = 1'b0;
        end else if (!STALL) begin
          w_ir_next       = INS_IN;
          w_ir_pc_next    = r_pc;
          w_ir_valid_next = 1'b1;
          w_pc_next       = r_pc + 4'd1;
          w_wrap_next     = (r_pc == c_PC_LAST);
        end
      end
      S_HALTED: begin
        w_ir_valid_next = 1'b0;
      end
      default: begin
        w_next_state    = S_IDLE;
        w_ir_valid_next = 1'b0;
      end
    endcase
    w_halted_next = (w_next_state == S_HALTED);
  end

  assign PC       = r_pc;
  assign IR       = r_ir;
  assign IR_PC    = r_ir_pc;
  assign IR_VALID = r_ir_valid;
  assign HALTED   = r_halted;
  assign WRAP     = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RUN = 1'b0;
  logic        STALL = 1'b0;
  logic        BR_TAKEN = 1'b0;
  logic [3:0]  BR_TARGET = 4'h0;
  logic        HALT_REQ = 1'b0;
  logic [10:0] INS_IN;
  logic [3:0]  PC;
  logic [10:0] IR;
  logic [3:0]  IR_PC;
  logic        IR_VALID;
  logic        HALTED;
  logic        WRAP;

  logic [10:0] mem [16];
  int total = 0;
  int bad = 0;

  // Behavioural model: "running" and "stopped" flags rather than a state code.
  bit          m_running, m_stopped;
  int          m_pc, m_ir_pc;
  logic [10:0] m_ir;
  bit          m_valid, m_wrap;

  fetch_unit #(.RESET_PC(4'h0)) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STALL(STALL), .BR_TAKEN(BR_TAKEN),
    .BR_TARGET(BR_TARGET), .HALT_REQ(HALT_REQ), .INS_IN(INS_IN),
    .PC(PC), .IR(IR), .IR_PC(IR_PC), .IR_VALID(IR_VALID),
    .HALTED(HALTED), .WRAP(WRAP)
  );

  always #5 CLK = ~CLK;
  always_comb INS_IN = mem[PC];

  function automatic logic [21:0] exp_vec();
    return {4'(m_pc), m_ir, 4'(m_ir_pc), m_valid, m_stopped, m_wrap};
  endfunction

  task automatic model_edge();
    if (RST) begin
      m_running = 0; m_stopped = 0; m_pc = 0; m_ir = '0; m_ir_pc = 0;
      m_valid = 0; m_wrap = 0;
    end else begin
      m_wrap = 0;
      if (m_stopped) m_valid = 0;
      else if (!m_running) begin
        m_valid = 0;
        if (RUN) m_running = 1;
      end else if (HALT_REQ) begin
        m_stopped = 1; m_valid = 0;
      end else if (BR_TAKEN) begin
        m_pc = int'(BR_TARGET); m_valid = 0;
      end else if (!STALL) begin
        m_ir = mem[m_pc]; m_ir_pc = m_pc; m_valid = 1;
        m_wrap = (m_pc == 15);
        m_pc = (m_pc + 1) % 16;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    RST = 0; RUN = 0; STALL = 0; BR_TAKEN = 0; HALT_REQ = 0; BR_TARGET = 4'h0;
  endtask

  task automatic do_reset();
    RST = 1; tick(); idle_inputs();
  endtask

  task automatic start_run();
    RUN = 1; tick(); RUN = 0;
  endtask

  task automatic test_reset();
    RUN = 1; STALL = 1; BR_TAKEN = 1; HALT_REQ = 1; BR_TARGET = 4'h7;
    RST = 1; tick(); idle_inputs();
    total++;
    if ({PC, IR, IR_PC, IR_VALID, HALTED, WRAP} !== 22'h0) begin
      bad++;
      $display("FAIL reset_values got=%h want=%h", {PC, IR, IR_PC, IR_VALID, HALTED, WRAP}, 22'h0);
    end
    tick();
    total++;
    if (IR_VALID !== 1'b0 || PC !== 4'h0) begin
      bad++;
      $display("FAIL idle_hold got pc=%h v=%b want pc=0 v=0", PC, IR_VALID);
    end
  endtask

  task automatic test_startup();
    for (int i = 0; i < 16; i++) mem[i] = 11'h100 + 11'(i);
    do_reset();
    start_run();
    total++;
    if (IR_VALID !== 1'b0 || PC !== 4'h0) begin
      bad++;
      $display("FAIL startup_e0 got pc=%h v=%b want pc=0 v=0", PC, IR_VALID);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (IR_PC !== 4'(k) || IR !== 11'h100 + 11'(k) || IR_VALID !== 1'b1 || PC !== 4'(k + 1)) begin
        bad++;
        $display("FAIL startup_seq%0d got irpc=%h ir=%h v=%b pc=%h want irpc=%h ir=%h v=1 pc=%h",
                 k, IR_PC, IR, IR_VALID, PC, 4'(k), 11'h100 + 11'(k), 4'(k + 1));
      end
    end
  endtask

  task automatic test_wrap();
    int wraps = 0;
    do_reset();
    start_run();
    for (int k = 0; k < 17; k++) begin
      tick();
      if (WRAP === 1'b1) wraps++;
      total++;
      if (IR_PC !== 4'(k % 16) || WRAP !== (k == 15)) begin
        bad++;
        $display("FAIL wrap_step%0d got irpc=%h wrap=%b want irpc=%h wrap=%b",
                 k, IR_PC, WRAP, 4'(k % 16), (k == 15));
      end
    end
    total++;
    if (wraps != 1) begin
      bad++;
      $display("FAIL wrap_count got=%0d want=1", wraps);
    end
  endtask

  // Free-run until the model shows the given PC with a valid IR, bounded.
  task automatic run_to_pc(input int target, input string name);
    int n = 0;
    while (!(m_pc == target && m_valid) && n < 40) begin
      tick(); n++;
    end
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL %s_timeout got cycles=%0d want <40", name, n);
    end
  endtask

  task automatic test_branch_over_stall();
    do_reset();
    start_run();
    run_to_pc(3, "branch");
    STALL = 1; BR_TAKEN = 1; BR_TARGET = 4'hA;
    tick();
    BR_TAKEN = 0; STALL = 0; BR_TARGET = 4'h0;
    total++;
    if (PC !== 4'hA || IR_VALID !== 1'b0 || WRAP !== 1'b0) begin
      bad++;
      $display("FAIL branch_bubble got pc=%h v=%b wrap=%b want pc=a v=0 wrap=0", PC, IR_VALID, WRAP);
    end
    tick();
    total++;
    if (IR_PC !== 4'hA || IR_VALID !== 1'b1 || IR !== mem[10] || PC !== 4'hB) begin
      bad++;
      $display("FAIL branch_target got irpc=%h v=%b ir=%h pc=%h want irpc=a v=1 ir=%h pc=b",
               IR_PC, IR_VALID, IR, PC, mem[10]);
    end
    // A branch to 0 is not an increment wrap.
    BR_TAKEN = 1; BR_TARGET = 4'h0;
    tick();
    BR_TAKEN = 0;
    total++;
    if (PC !== 4'h0 || WRAP !== 1'b0) begin
      bad++;
      $display("FAIL branch_zero got pc=%h wrap=%b want pc=0 wrap=0", PC, WRAP);
    end
  endtask

  task automatic test_stall();
    logic [10:0] held_ir;
    logic [3:0]  held_irpc;
    do_reset();
    start_run();
    run_to_pc(5, "stall");
    held_ir = mem[4]; held_irpc = 4'h4;
    STALL = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (PC !== 4'h5 || IR !== held_ir || IR_PC !== held_irpc || IR_VALID !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold%0d got pc=%h ir=%h irpc=%h v=%b want pc=5 ir=%h irpc=4 v=1",
                 k, PC, IR, IR_PC, IR_VALID, held_ir);
      end
    end
    STALL = 0;
    tick();
    total++;
    if (IR_PC !== 4'h5 || IR !== mem[5] || PC !== 4'h6) begin
      bad++;
      $display("FAIL stall_release got irpc=%h ir=%h pc=%h want irpc=5 ir=%h pc=6", IR_PC, IR, PC, mem[5]);
    end
  endtask

  task automatic test_halt();
    do_reset();
    start_run();
    run_to_pc(7, "halt");
    HALT_REQ = 1; BR_TAKEN = 1; BR_TARGET = 4'h2;
    tick();
    idle_inputs();
    total++;
    if (HALTED !== 1'b1 || IR_VALID !== 1'b0 || PC !== 4'h7 || IR_PC !== 4'h6) begin
      bad++;
      $display("FAIL halt_enter got h=%b v=%b pc=%h irpc=%h want h=1 v=0 pc=7 irpc=6", HALTED, IR_VALID, PC, IR_PC);
    end
    for (int k = 0; k < 4; k++) begin
      RUN = 1; BR_TAKEN = 1; BR_TARGET = 4'(k + 1); STALL = k[0];
      tick();
      total++;
      if (HALTED !== 1'b1 || IR_VALID !== 1'b0 || PC !== 4'h7) begin
        bad++;
        $display("FAIL halt_sticky%0d got h=%b v=%b pc=%h want h=1 v=0 pc=7", k, HALTED, IR_VALID, PC);
      end
    end
    RST = 1; tick(); idle_inputs();
    total++;
    if (HALTED !== 1'b0 || PC !== 4'h0 || IR_VALID !== 1'b0) begin
      bad++;
      $display("FAIL halt_reset got h=%b pc=%h v=%b want h=0 pc=0 v=0", HALTED, PC, IR_VALID);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    start_run();
    run_to_pc(9, "midrst");
    RST = 1; tick(); idle_inputs();
    total++;
    if ({PC, IR, IR_PC, IR_VALID, HALTED, WRAP} !== 22'h0) begin
      bad++;
      $display("FAIL midrst_values got=%h want=%h", {PC, IR, IR_PC, IR_VALID, HALTED, WRAP}, 22'h0);
    end
    start_run();
    tick();
    total++;
    if (IR_PC !== 4'h0 || IR_VALID !== 1'b1 || IR !== mem[0]) begin
      bad++;
      $display("FAIL midrst_restart got irpc=%h v=%b ir=%h want irpc=0 v=1 ir=%h", IR_PC, IR_VALID, IR, mem[0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) mem[i] = 11'($urandom);
    do_reset();
    for (int c = 0; c < 400; c++) begin
      RST       = ($urandom_range(0, 59) == 0);
      RUN       = ($urandom_range(0, 3) == 0);
      STALL     = ($urandom_range(0, 3) == 0);
      BR_TARGET = 4'($urandom);
      // Control from execute only arrives while a valid word is in IR.
      BR_TAKEN  = m_running && m_valid && ($urandom_range(0, 7) == 0);
      HALT_REQ  = m_running && m_valid && ($urandom_range(0, 39) == 0);
      tick();
      total++;
      if ({PC, IR, IR_PC, IR_VALID, HALTED, WRAP} !== exp_vec()) begin
        bad++;
        $display("FAIL random_c%0d got pc=%h ir=%h irpc=%h v=%b h=%b w=%b want {pc,ir,irpc,v,h,w}=%h",
                 c, PC, IR, IR_PC, IR_VALID, HALTED, WRAP, exp_vec());
      end
      // Keep the random run from sitting halted for long.
      if (m_stopped && $urandom_range(0, 5) == 0) begin
        RST = 1; tick(); RST = 0;
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_startup();
    test_wrap();
    test_branch_over_stall();
    test_stall();
    test_halt();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
